mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the pipelined processor's IMEM and DMEM bus ports.
//  It serves combinational instruction fetch and DMEM loads, commits DMEM stores
//  at the clock edge, and clears the array with a post-reset FSM. It also keeps
//  sticky error flags for illegal accesses. Sits in the top level/testbench
//  between the processor and the backing word array.
// PARAMETERS
//  DEPTH_WORDS  16384     array size in 32-bit words (power of 2)
//  ADDR_BASE    32'h0     byte address of word 0; must be word aligned
// PORTS
//  clk               in   1   clock
//  rst               in   1   reset, asynchronous, active-high
//  im_command        in   2   IMEM command; `BUS_LOAD = fetch, else idle
//  pc_addr           in   32  IMEM byte address
//  instruction       out  32  fetched word
//  proc2Dmem_command in   2   `BUS_NONE / `BUS_LOAD / `BUS_STORE (sys_defs.vh)
//  proc2Dmem_addr    in   32  DMEM byte address
//  proc2Dmem_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  proc2mem_data     in   32  store data, LSB-justified
//  mem2proc_data     out  32  load data, zero-extended to 32
//  mem_ready         out  1   1 = init done, accesses serviced
//  mem_err           out  1   sticky error flag
//  mem_err_addr      out  32  address of the first error
//  load_count        out  32  serviced DMEM loads (see CONFIGURATION)
//  store_count       out  32  committed DMEM stores (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: mem_ready=0, mem_err=0, mem_err_addr=0, counters=0. FSM enters INIT with idx=0.
//  FSM INIT:
//   - Writes 0 to word idx each cycle; idx++.
//   - On idx==DEPTH_WORDS-1 the FSM goes to READY at the next edge, so it takes
//     exactly DEPTH_WORDS cycles.
//   - In INIT: all commands are ignored, instruction=`NOOP_INST, mem2proc_data=0,
//     no errors are logged.
//  FSM READY: terminal state; only rst leaves it. Reset mid-INIT restarts at idx=0.
//  Word index = (addr-ADDR_BASE)>>2. Out of range: addr<ADDR_BASE or index>=DEPTH_WORDS.
//  IMEM reads (READY):
//   - Combinational, zero latency: instruction = array[index(pc_addr)].
//   - pc_addr[1:0]!=0 or out of range -> `NOOP_INST, and an error is logged.
//   - Idle im_command -> `NOOP_INST.
//  DMEM load (READY):
//   - Combinational, zero latency.
//   - Data = word >> (8*addr[1:0]), masked to 8/16/32 bits by size.
//   - Sign extension is done in the processor, not here.
//  DMEM store (READY):
//   - Byte lanes from size and addr[1:0]; written at posedge clk.
//   - A load or fetch in the same cycle returns the pre-store contents.
//   - The new value is visible from the next cycle.
//  Illegal DMEM access (misaligned half/word, size 11, out of range, reserved
//  command 11): stores are dropped, loads return 0, and an error is logged.
//  Error logging: mem_err is set at the next edge. mem_err_addr captures only the
//  first error (DMEM has priority over IMEM in the same cycle). Only rst clears either.
//  Counters: +1 at the edge for each legal serviced access; 32-bit wrap 32'hFFFFFFFF->0.
// CONFIGURATION
//  MEM_RESP_STATS_EN defined: load_count and store_count are implemented as above.
//  MEM_RESP_STATS_EN undefined: no counter flops; load_count and store_count
//  are tied to 32'h0. All other behaviour is identical.
// TESTING
//  1. DEPTH_WORDS=16, rst pulse:
//     - mem_ready=0 for 16 cycles, then 1.
//     - Every word reads 0.
//     - In INIT, instruction=`NOOP_INST and a store is dropped.
//  2. Word store 32'hDEADBEEF @0x40, then load word @0x40 next cycle:
//     - Data returned is 32'hDEADBEEF.
//     - A fetch from pc_addr 0x40 in the store cycle returns the old value 0.
//  3. Byte store 8'hA5 @0x41 over 32'h11223344 @0x40:
//     - The word becomes 32'h1122A544.
//     - Half load @0x42 returns 32'h00001122.
//  4. Half store @0x43:
//     - Word unchanged, mem_err=1, mem_err_addr=0x43.
//     - A later out-of-range load returns 0 and mem_err_addr stays 0x43.
//  5. Assert rst mid-INIT (idx=7): FSM restarts and mem_ready rises exactly
//     DEPTH_WORDS cycles after rst deasserts.
//  6. With MEM_RESP_STATS_EN: 3 loads and 2 stores give counts 3/2. Preset the
//     count to 32'hFFFFFFFF via force and load once: the count wraps to 0.

Source files
------------

// File: rtl/mem_responder_if.sv
// ============================================================================
// Module      : mem_responder_if
// Description : IMEM/DMEM bus bundle between the processor and mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic [1:0]  im_command;
  logic [31:0] pc_addr;
  logic [31:0] instruction;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [1:0]  proc2Dmem_size;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic        mem_ready;
  logic        mem_err;
  logic [31:0] mem_err_addr;
  logic [31:0] load_count;
  logic [31:0] store_count;

  modport master (
    output im_command, pc_addr, proc2Dmem_command, proc2Dmem_addr,
           proc2Dmem_size, proc2mem_data,
    input  instruction, mem2proc_data, mem_ready, mem_err, mem_err_addr,
           load_count, store_count
  );

  modport slave (
    input  im_command, pc_addr, proc2Dmem_command, proc2Dmem_addr,
           proc2Dmem_size, proc2mem_data,
    output instruction, mem2proc_data, mem_ready, mem_err, mem_err_addr,
           load_count, store_count
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for IMEM fetch and DMEM load/store with a
//               post-reset clearing FSM and sticky error capture.
//               Optional access counters are built when MEM_RESP_STATS_EN is
//               defined; otherwise load_count/store_count read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned      IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [1:0]       BUS_NONE  = 2'b00;
  localparam logic [1:0]       BUS_LOAD  = 2'b01;
  localparam logic [1:0]       BUS_STORE = 2'b10;
  localparam logic [31:0]      NOOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mem_ready_q, mem_ready_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [29:0]      i_word;
  logic             i_ok, i_fetch, i_err;
  logic [29:0]      d_word;
  logic             d_inr, d_algn, d_active, d_load, d_store, d_err;
  logic [31:0]      d_shifted, d_rdata;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  // Word offsets are taken on addr[31:2]; ADDR_BASE is word aligned.
  always_comb begin
    i_word  = bus.pc_addr[31:2] - ADDR_BASE[31:2];
    i_ok    = (bus.pc_addr >= ADDR_BASE) && ({2'b00, i_word} < 32'(DEPTH_WORDS))
              && (bus.pc_addr[1:0] == 2'b00);
    i_fetch = (state_q == S_READY) && (bus.im_command == BUS_LOAD);
    i_err   = i_fetch && !i_ok;
    bus.instruction = (i_fetch && i_ok) ? mem_q[i_word[IDX_W-1:0]] : NOOP_INST;
  end

  always_comb begin
    d_word = bus.proc2Dmem_addr[31:2] - ADDR_BASE[31:2];
    d_inr  = (bus.proc2Dmem_addr >= ADDR_BASE) && ({2'b00, d_word} < 32'(DEPTH_WORDS));
    case (bus.proc2Dmem_size)
      2'b00:   d_algn = 1'b1;
      2'b01:   d_algn = ~bus.proc2Dmem_addr[0];
      2'b10:   d_algn = (bus.proc2Dmem_addr[1:0] == 2'b00);
      default: d_algn = 1'b0;
    endcase
    d_active = (state_q == S_READY) && (bus.proc2Dmem_command != BUS_NONE);
    d_load   = d_active && (bus.proc2Dmem_command == BUS_LOAD)  && d_algn && d_inr;
    d_store  = d_active && (bus.proc2Dmem_command == BUS_STORE) && d_algn && d_inr;
    d_err    = d_active && !(d_load || d_store);

    d_shifted = mem_q[d_word[IDX_W-1:0]] >> {bus.proc2Dmem_addr[1:0], 3'b000};
    case (bus.proc2Dmem_size)
      2'b00:   d_rdata = {24'h0, d_shifted[7:0]};
      2'b01:   d_rdata = {16'h0, d_shifted[15:0]};
      default: d_rdata = d_shifted;
    endcase
    bus.mem2proc_data = d_load ? d_rdata : 32'h0;
  end

  // The single write port is shared by the clearing sweep and DMEM stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = d_word[IDX_W-1:0];
    wr_be   = 4'h0;
    wr_data = bus.proc2mem_data << {bus.proc2Dmem_addr[1:0], 3'b000};
    if (state_q == S_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = idx_q;
      wr_be   = 4'hF;
      wr_data = 32'h0;
    end else if (d_store) begin
      wr_en = 1'b1;
      case (bus.proc2Dmem_size)
        2'b00:   wr_be = 4'b0001 << bus.proc2Dmem_addr[1:0];
        2'b01:   wr_be = 4'b0011 << bus.proc2Dmem_addr[1:0];
        default: wr_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_ready_d = mem_ready_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (state_q == S_INIT) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        state_d     = S_READY;
        mem_ready_d = 1'b1;
        idx_d       = '0;
      end
    end
    // Only the first error is captured; DMEM wins a same-cycle tie.
    if (!err_q && d_err) begin
      err_d      = 1'b1;
      err_addr_d = bus.proc2Dmem_addr;
    end else if (!err_q && i_err) begin
      err_d      = 1'b1;
      err_addr_d = bus.pc_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.mem_ready    = mem_ready_q;
  assign bus.mem_err      = err_q;
  assign bus.mem_err_addr = err_addr_q;

`ifdef MEM_RESP_STATS_EN
  logic [31:0] load_count_q, load_count_d;
  logic [31:0] store_count_q, store_count_d;

  always_comb begin
    load_count_d  = load_count_q  + 32'(d_load);
    store_count_d = store_count_q + 32'(d_store);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count_q  <= 32'h0;
      store_count_q <= 32'h0;
    end else begin
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign bus.load_count  = load_count_q;
  assign bus.store_count = store_count_q;
`else
  assign bus.load_count  = 32'h0;
  assign bus.store_count = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam logic [31:0] NOOP  = 32'h0000_0013;
  localparam logic [1:0]  C_NONE = 2'b00, C_LOAD = 2'b01, C_STORE = 2'b10, C_RSVD = 2'b11;
  localparam logic [1:0]  SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
    logic [31:0] lc;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] mdl [DEPTH];
  int          init_left;
  logic        merr;
  logic [31:0] merr_addr;
  logic [31:0] mlc, msc;

  function automatic bit m_inr(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return ((a - BASE) / 4) < DEPTH;
  endfunction

  function automatic int m_widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic bit m_dlegal(input logic [1:0] c, input logic [31:0] a, input logic [1:0] s);
    int nb;
    if (!(c == C_LOAD || c == C_STORE) || s == SZ_X) return 1'b0;
    nb = 1 << s;
    return (a % nb == 0) && m_inr(a);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] w, v;
    int k;
    w = mdl[m_widx(a)];
    v = 32'h0;
    k = int'(a % 4);
    for (int b = 0; b < (1 << s); b++) v[8*b +: 8] = w[8*(k+b) +: 8];
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int k, i;
    k = int'(a % 4);
    i = m_widx(a);
    for (int b = 0; b < (1 << s); b++) mdl[i][8*(k+b) +: 8] = d[8*b +: 8];
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", tag, nm, got, exp);
    end
  endtask

  function automatic exp_t snap(input string tag, input bit rdy);
    exp_t e;
    e.tag = tag; e.ready = rdy; e.instr = NOOP; e.rdata = 32'h0;
    e.err = merr; e.err_addr = merr_addr;
`ifdef MEM_RESP_STATS_EN
    e.lc = mlc; e.sc = msc;
`else
    e.lc = 32'h0; e.sc = 32'h0;
`endif
    return e;
  endfunction

  // Drive one cycle at the falling edge, predict outputs, advance the model.
  task automatic step(input string tag, input logic [1:0] ic, input logic [31:0] pc,
                      input logic [1:0] dc, input logic [31:0] da, input logic [1:0] ds,
                      input logic [31:0] wd);
    exp_t e;
    bit rdy, ierr, derr, dleg;
    bus.im_command = ic;  bus.pc_addr = pc;
    bus.proc2Dmem_command = dc; bus.proc2Dmem_addr = da;
    bus.proc2Dmem_size = ds; bus.proc2mem_data = wd;
    rdy = (init_left == 0);
    e = snap(tag, rdy);
    ierr = 1'b0; derr = 1'b0;
    if (rdy) begin
      if (ic == C_LOAD) begin
        if (pc % 4 == 0 && m_inr(pc)) e.instr = mdl[m_widx(pc)];
        else ierr = 1'b1;
      end
      if (dc != C_NONE) begin
        dleg = m_dlegal(dc, da, ds);
        derr = !dleg;
        if (dleg && dc == C_LOAD)  begin e.rdata = m_load(da, ds); mlc = mlc + 1; end
        if (dleg && dc == C_STORE) begin m_store(da, ds, wd); msc = msc + 1; end
      end
      if (!merr && (derr || ierr)) begin
        merr = 1'b1;
        merr_addr = derr ? da : pc;
      end
    end else begin
      init_left--;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, C_NONE, 32'h0, C_NONE, 32'h0, SZ_W, 32'h0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    bus.im_command = C_NONE; bus.pc_addr = 32'h0;
    bus.proc2Dmem_command = C_NONE; bus.proc2Dmem_addr = 32'h0;
    bus.proc2Dmem_size = SZ_W; bus.proc2mem_data = 32'h0;
    init_left = DEPTH; merr = 1'b0; merr_addr = 32'h0; mlc = 32'h0; msc = 32'h0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    sb.push_back(snap("reset", 1'b0));
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_init();
    while (init_left > 0) idle("init_wait");
  endtask

  // Monitor: compares every cycle in which a prediction is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "mem_ready",    32'(bus.mem_ready), 32'(e.ready));
        chk(e.tag, "instruction",  bus.instruction,    e.instr);
        chk(e.tag, "rdata",        bus.mem2proc_data,  e.rdata);
        chk(e.tag, "mem_err",      32'(bus.mem_err),   32'(e.err));
        chk(e.tag, "mem_err_addr", bus.mem_err_addr,   e.err_addr);
        chk(e.tag, "load_count",   bus.load_count,     e.lc);
        chk(e.tag, "store_count",  bus.store_count,    e.sc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [1:0] ic, dc, ds;
    logic [31:0] pc, da;
    int r;

    @(negedge clk);
    do_reset(2);

    // Clearing phase: fetches give NOOP, stores and reserved commands ignored
    for (int i = 0; i < DEPTH; i++) begin
      step("init", C_LOAD, BASE, (i % 4 == 3) ? C_RSVD : C_STORE, BASE, SZ_W, 32'hCAFE_F00D);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step("clr", C_LOAD, BASE + 32'(4*i), C_LOAD, BASE + 32'(4*i), SZ_W, 32'h0);
    end

    step("st_dead", C_LOAD, 32'h40, C_STORE, 32'h40, SZ_W, 32'hDEAD_BEEF);
    step("ld_dead", C_LOAD, 32'h40, C_LOAD,  32'h40, SZ_W, 32'h0);

    step("st_word", C_NONE, 32'h0, C_STORE, 32'h40, SZ_W, 32'h1122_3344);
    step("st_byte", C_NONE, 32'h0, C_STORE, 32'h41, SZ_B, 32'hFFFF_FFA5);
    step("ld_word", C_LOAD, 32'h40, C_LOAD, 32'h40, SZ_W, 32'h0);
    step("ld_half", C_NONE, 32'h0, C_LOAD, 32'h42, SZ_H, 32'h0);
    step("ld_byte", C_NONE, 32'h0, C_LOAD, 32'h43, SZ_B, 32'h0);

    step("st_mis",  C_NONE, 32'h0, C_STORE, 32'h43, SZ_H, 32'h0000_BEEF);
    step("ld_chk",  C_NONE, 32'h0, C_LOAD,  32'h40, SZ_W, 32'h0);
    step("ld_oor",  C_NONE, 32'h0, C_LOAD,  32'h80, SZ_W, 32'h0);
    step("ld_low",  C_NONE, 32'h0, C_LOAD,  32'h3C, SZ_W, 32'h0);
    idle("err_hold");

`ifdef MEM_RESP_STATS_EN
    force dut.load_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.load_count_q;
    mlc = 32'hFFFF_FFFF;
    step("wrap_ld", C_NONE, 32'h0, C_LOAD, 32'h44, SZ_W, 32'h0);
    idle("wrap_chk");
`endif

    // Reset part way through clearing, then time the restart
    do_reset(1);
    for (int i = 0; i < 7; i++) idle("init_a");
    do_reset(1);
    wait_init();
    idle("ready_again");

    // Same-cycle IMEM and DMEM errors: DMEM address is captured
    step("both_err", C_LOAD, BASE + 32'h2, C_LOAD, BASE + 32'h10, SZ_X, 32'h0);
    step("both_chk", C_LOAD, BASE + 32'h5, C_STORE, 32'h0, SZ_W, 32'h0);
    idle("both_hold");

    // IMEM-only first error
    do_reset(1);
    wait_init();
    step("im_err", C_LOAD, 32'h90, C_NONE, 32'h0, SZ_W, 32'h0);
    idle("im_chk");

    // Randomized traffic
    do_reset(1);
    wait_init();
    for (int n = 0; n < 400; n++) begin
      ic = 2'($urandom_range(0, 3));
      pc = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32'h30, 32'h8F))
                                        : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      r  = int'($urandom_range(0, 9));
      dc = (r < 4) ? C_LOAD : (r < 8) ? C_STORE : (r == 8) ? C_NONE : C_RSVD;
      da = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32'h30, 32'h8F))
                                        : BASE + 32'($urandom_range(0, 4*DEPTH - 1));
      ds = ($urandom_range(0, 15) == 0) ? SZ_X : 2'($urandom_range(0, 2));
      if (dc != C_RSVD && ds != SZ_X && $urandom_range(0, 3) != 0) begin
        da = da & ~((32'h1 << ds) - 32'h1);
      end
      step("rand", ic, pc, dc, da, ds, $urandom);
    end
    idle("rand_end");

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
